chacha_round_engine: RTL and testbench

//   Iterative ChaCha block-function engine, directly upstream of and driving four

---
 rtl/chacha_pkg.sv | 50 +++++
 rtl/chacha_round_engine_if.sv | 22 ++
 rtl/chacha_round_engine_qr.sv | 32 +++
 rtl/chacha_round_engine.sv | 142 ++++++++++++++
 tb/tb_chacha_round_engine.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/chacha_pkg.sv
// Shared types, word helpers and quarter-round index tables for the ChaCha block engine.
package chacha_pkg;

  localparam int CHACHA_WORDS   = 16;
  localparam int CHACHA_WORD_W  = 32;
  localparam int CHACHA_BLOCK_W = 512;

  typedef logic [CHACHA_WORD_W-1:0]  word_t;
  typedef logic [CHACHA_BLOCK_W-1:0] block_t;
  typedef logic [3:0]                idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Row q lists the a/b/c/d word indices fed to quarter-round q.
  localparam idx_t COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam idx_t DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  // Word 0 sits in the most significant 32 bits of the block.
  function automatic word_t get_word(input block_t v, input idx_t i);
    return v[CHACHA_BLOCK_W-1-CHACHA_WORD_W*int'(i) -: CHACHA_WORD_W];
  endfunction

  function automatic block_t set_word(input block_t v, input idx_t i, input word_t w);
    block_t r;
    r = v;
    r[CHACHA_BLOCK_W-1-CHACHA_WORD_W*int'(i) -: CHACHA_WORD_W] = w;
    return r;
  endfunction

  function automatic word_t rotl(input word_t v, input int unsigned n);
    return (v << n) | (v >> (CHACHA_WORD_W - n));
  endfunction

endpackage

// File: rtl/chacha_round_engine_if.sv
// Init-state and keystream-block valid/ready handshakes of the ChaCha round engine.
interface chacha_round_engine_if;
  import chacha_pkg::*;

  logic   init_valid;
  logic   init_ready;
  block_t init_state;
  logic   block_valid;
  logic   block_ready;
  block_t block_out;

  // master: state assembler upstream plus keystream consumer downstream.
  modport master (
    output init_valid, init_state, block_ready,
    input  init_ready, block_valid, block_out
  );

  modport slave (
    input  init_valid, init_state, block_ready,
    output init_ready, block_valid, block_out
  );
endinterface

// File: rtl/chacha_round_engine_qr.sv
// Combinational ChaCha quarter-round on four 32-bit words.
module chacha_qr
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_new,
  output word_t b_new,
  output word_t c_new,
  output word_t d_new
);

  word_t a1, b1, c1, d1;
  word_t a2, b2, c2, d2;

  assign a1 = a + b;
  assign d1 = rotl(d ^ a1, 16);
  assign c1 = c + d1;
  assign b1 = rotl(b ^ c1, 12);
  assign a2 = a1 + b1;
  assign d2 = rotl(d1 ^ a2, 8);
  assign c2 = c1 + d2;
  assign b2 = rotl(b1 ^ c2, 7);

  assign a_new = a2;
  assign b_new = b2;
  assign c_new = c2;
  assign d_new = d2;

endmodule

// File: rtl/chacha_round_engine.sv
// Iterative ChaCha block function: one column or diagonal round per cycle, then
// feed-forward addition of the initial state, presented on a valid/ready output.
module chacha_round_engine
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  chacha_round_engine_if.slave   bus,
  output logic                   busy
);

  localparam int                CTR_W    = $clog2(ROUNDS);
  localparam logic [CTR_W-1:0]  LAST_RND = CTR_W'(ROUNDS - 1);

  state_t            state, state_next;
  logic [CTR_W-1:0]  round_ctr;
  block_t            x_reg, orig_reg, block_reg;
  logic              valid_reg;
  logic              load, step_rnd, finish, release_blk;

  idx_t   sel [4][4];
  word_t  qa [4], qb [4], qc [4], qd [4];
  word_t  na [4], nb [4], nc [4], nd [4];
  block_t x_next, sum;

  // Control: state register and next-state decode
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load        = 1'b0;
    step_rnd    = 1'b0;
    finish      = 1'b0;
    release_blk = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.init_valid) begin
          load       = 1'b1;
          state_next = ST_ROUND;
        end
      end
      ST_ROUND: begin
        step_rnd = 1'b1;
        if (round_ctr == LAST_RND) state_next = ST_FINAL;
      end
      ST_FINAL: begin
        finish     = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (valid_reg && bus.block_ready) begin
          release_blk = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.init_ready  = (state == ST_IDLE) && !reset;
  assign bus.block_valid = valid_reg;
  assign bus.block_out   = block_reg;
  assign busy            = (state == ST_ROUND) || (state == ST_FINAL);

  // Round datapath: gather words for the four quarter-rounds
  always_comb begin
    for (int q = 0; q < 4; q++) begin
      for (int k = 0; k < 4; k++) begin
        sel[q][k] = round_ctr[0] ? DIAG_IDX[q][k] : COL_IDX[q][k];
      end
    end
  end

  always_comb begin
    for (int q = 0; q < 4; q++) begin
      qa[q] = get_word(x_reg, sel[q][0]);
      qb[q] = get_word(x_reg, sel[q][1]);
      qc[q] = get_word(x_reg, sel[q][2]);
      qd[q] = get_word(x_reg, sel[q][3]);
    end
  end

  chacha_qr qr0 (.a(qa[0]), .b(qb[0]), .c(qc[0]), .d(qd[0]),
                 .a_new(na[0]), .b_new(nb[0]), .c_new(nc[0]), .d_new(nd[0]));
  chacha_qr qr1 (.a(qa[1]), .b(qb[1]), .c(qc[1]), .d(qd[1]),
                 .a_new(na[1]), .b_new(nb[1]), .c_new(nc[1]), .d_new(nd[1]));
  chacha_qr qr2 (.a(qa[2]), .b(qb[2]), .c(qc[2]), .d(qd[2]),
                 .a_new(na[2]), .b_new(nb[2]), .c_new(nc[2]), .d_new(nd[2]));
  chacha_qr qr3 (.a(qa[3]), .b(qb[3]), .c(qc[3]), .d(qd[3]),
                 .a_new(na[3]), .b_new(nb[3]), .c_new(nc[3]), .d_new(nd[3]));

  // Scatter back: every word belongs to exactly one quarter-round per round.
  always_comb begin
    x_next = x_reg;
    for (int q = 0; q < 4; q++) begin
      x_next = set_word(x_next, sel[q][0], na[q]);
      x_next = set_word(x_next, sel[q][1], nb[q]);
      x_next = set_word(x_next, sel[q][2], nc[q]);
      x_next = set_word(x_next, sel[q][3], nd[q]);
    end
  end

  // Feed-forward: per-word modular add, carries never cross word boundaries.
  always_comb begin
    sum = '0;
    for (int i = 0; i < CHACHA_WORDS; i++) begin
      sum = set_word(sum, idx_t'(i), get_word(x_reg, idx_t'(i)) + get_word(orig_reg, idx_t'(i)));
    end
  end

  // Registers: working state, original state, output block
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg     <= '0;
      orig_reg  <= '0;
      block_reg <= '0;
      valid_reg <= 1'b0;
      round_ctr <= '0;
    end else begin
      if (load) begin
        x_reg     <= bus.init_state;
        orig_reg  <= bus.init_state;
        round_ctr <= '0;
      end else if (step_rnd) begin
        x_reg     <= x_next;
        round_ctr <= round_ctr + CTR_W'(1);
      end
      if (finish) begin
        block_reg <= sum;
        valid_reg <= 1'b1;
      end else if (release_blk) begin
        valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chacha_round_engine.sv
// Randomized bench for chacha_round_engine against a word-array ChaCha reference model.
module tb_chacha_round_engine;
  import chacha_pkg::*;

  localparam int ROUNDS = 20;
  localparam int LIMIT  = 200;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  chacha_round_engine_if bus ();

  chacha_round_engine #(.ROUNDS(ROUNDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam block_t RFC_IN = {
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
    32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
    32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
    32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
  localparam block_t RFC_OUT = {
    32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
    32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
    32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
    32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // ChaCha block function as written in the RFC: word array, explicit rounds.
  function automatic block_t ref_block(input block_t s);
    logic [31:0] x [16];
    logic [31:0] o [16];
    logic [31:0] a, b, c, d;
    int ia, ib, ic, id;
    block_t r;
    for (int i = 0; i < 16; i++) begin
      o[i] = s[511-32*i -: 32];
      x[i] = o[i];
    end
    for (int rn = 0; rn < ROUNDS; rn++) begin
      for (int q = 0; q < 4; q++) begin
        ia = q;
        if (rn % 2 == 0) begin
          ib = q + 4; ic = q + 8; id = q + 12;
        end else begin
          ib = 4 + (q + 1) % 4; ic = 8 + (q + 2) % 4; id = 12 + (q + 3) % 4;
        end
        a = x[ia]; b = x[ib]; c = x[ic]; d = x[id];
        a = a + b; d = rl(d ^ a, 16);
        c = c + d; b = rl(b ^ c, 12);
        a = a + b; d = rl(d ^ a, 8);
        c = c + d; b = rl(b ^ c, 7);
        x[ia] = a; x[ib] = b; x[ic] = c; x[id] = d;
      end
    end
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + o[i];
    return r;
  endfunction

  function automatic block_t rand_block();
    block_t r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input block_t s);
    int n;
    n = 0;
    while (!bus.init_ready && n < LIMIT) begin
      step();
      n++;
    end
    check_val("init_ready_wait", 512'(bus.init_ready), 512'(1));
    bus.init_state = s;
    bus.init_valid = 1'b1;
    step();
    bus.init_valid = 1'b0;
  endtask

  task automatic wait_block(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (!bus.block_valid && lat < LIMIT) begin
      if (busy) bcyc++;
      step();
      lat++;
    end
  endtask

  task automatic run_block(input string tag, input block_t s);
    int lat, bcyc;
    start_block(s);
    wait_block(lat, bcyc);
    check_val({tag, "_latency"}, 512'(lat), 512'(ROUNDS + 1));
    check_val({tag, "_busy_cycles"}, 512'(bcyc), 512'(ROUNDS + 1));
    check_val({tag, "_data"}, bus.block_out, ref_block(s));
    bus.block_ready = 1'b1;
    step();
    bus.block_ready = 1'b0;
    check_val({tag, "_valid_fall"}, 512'(bus.block_valid), 512'(0));
    check_val({tag, "_ready_back"}, 512'(bus.init_ready), 512'(1));
  endtask

  initial begin
    block_t saved, st;
    block_t sts [5];
    int starts [5];
    int lat, bcyc;

    reset           = 1'b1;
    bus.init_valid  = 1'b0;
    bus.init_state  = '0;
    bus.block_ready = 1'b0;
    repeat (3) step();
    check_val("rst_block_valid", 512'(bus.block_valid), 512'(0));
    check_val("rst_block_out", bus.block_out, 512'(0));
    check_val("rst_busy", 512'(busy), 512'(0));
    check_val("rst_init_ready", 512'(bus.init_ready), 512'(0));
    reset = 1'b0;
    #1;
    check_val("init_ready_after_rst", 512'(bus.init_ready), 512'(1));

    run_block("zero", '0);
    check_val("zero_out", bus.block_out, 512'(0));

    run_block("rfc", RFC_IN);
    check_val("rfc_word0", 512'(bus.block_out[511 -: 32]), 512'(32'he4e7f110));
    check_val("rfc_word1", 512'(bus.block_out[479 -: 32]), 512'(32'h15593bd1));
    check_val("rfc_word15", 512'(bus.block_out[31:0]), 512'(32'h4e3c50a2));
    check_val("rfc_full", bus.block_out, RFC_OUT);

    // Backpressure with ignored init pulses while the block is held
    st = rand_block();
    start_block(st);
    wait_block(lat, bcyc);
    check_val("bp_latency", 512'(lat), 512'(ROUNDS + 1));
    saved = bus.block_out;
    check_val("bp_data", saved, ref_block(st));
    for (int i = 0; i < 10; i++) begin
      bus.init_valid = 1'b1;
      bus.init_state = rand_block();
      step();
      bus.init_valid = 1'b0;
      check_val("bp_stable", bus.block_out, saved);
      check_val("bp_init_ready", 512'(bus.init_ready), 512'(0));
      check_val("bp_valid_held", 512'(bus.block_valid), 512'(1));
    end
    bus.block_ready = 1'b1;
    step();
    bus.block_ready = 1'b0;
    check_val("bp_valid_fall", 512'(bus.block_valid), 512'(0));
    check_val("bp_ready_back", 512'(bus.init_ready), 512'(1));
    check_val("bp_retained", bus.block_out, saved);
    step();
    check_val("bp_no_restart", 512'(busy), 512'(0));

    // Reset during round 7
    start_block(rand_block());
    repeat (7) step();
    check_val("mid_busy_before", 512'(busy), 512'(1));
    reset = 1'b1;
    step();
    check_val("mid_rst_valid", 512'(bus.block_valid), 512'(0));
    check_val("mid_rst_out", bus.block_out, 512'(0));
    check_val("mid_rst_busy", 512'(busy), 512'(0));
    check_val("mid_rst_ready", 512'(bus.init_ready), 512'(0));
    reset = 1'b0;
    #1;
    run_block("post_rst_rfc", RFC_IN);
    check_val("post_rst_word0", 512'(bus.block_out[511 -: 32]), 512'(32'he4e7f110));

    for (int i = 0; i < 20; i++) run_block("rand", rand_block());

    // Back-to-back with init_valid and block_ready tied high
    bus.block_ready = 1'b1;
    bus.init_valid  = 1'b1;
    for (int b = 0; b < 5; b++) begin
      int n;
      sts[b] = rand_block();
      n = 0;
      while (!bus.init_ready && n < LIMIT) begin
        step();
        n++;
      end
      check_val("b2b_ready_wait", 512'(bus.init_ready), 512'(1));
      bus.init_state = sts[b];
      step();
      starts[b] = cyc;
      wait_block(lat, bcyc);
      check_val("b2b_latency", 512'(lat), 512'(ROUNDS + 1));
      check_val("b2b_data", bus.block_out, ref_block(sts[b]));
      if (b > 0) check_val("b2b_interval", 512'(starts[b] - starts[b-1]), 512'(ROUNDS + 3));
    end
    bus.init_valid = 1'b0;
    step();
    bus.block_ready = 1'b0;
    check_val("b2b_final_release", 512'(bus.block_valid), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
